// File: rtl/fir_sample_feeder.sv
// Sample feeder for a multi-cycle FIR filter.
// Buffers upstream samples in a small FIFO. Each sample is then held on fir_sig
// while fir_ready pulses for TAPS cycles. The filter result for the previous
// sample is captured into a one-entry output register during the next burst.
module fir_sample_feeder #(
    parameter int WIDTH = 18,
    parameter int TAPS  = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] fir_sig,
    output logic             fir_ready,
    input  logic [WIDTH-1:0] fir_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);
    localparam logic [CW-1:0] CNT_CAPT = CW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             primed;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy flags come straight from the registered count, so a pop in the
    // same cycle never lets a push into a full FIFO.
    always_comb begin
        full    = (count == CNT_FULL);
        empty   = (count == '0);
        s_ready = ~full;
        push    = s_valid & ~full;
        pop     = (state == IDLE) & ~empty & ~m_valid;
        busy    = (state == BURST);
    end

    // FIFO storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy, wrapping naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Burst sequencer with registered filter-side outputs and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            primed    <= 1'b0;
            fir_sig   <= '0;
            fir_ready <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        fir_sig   <= mem[rd_ptr];
                        cnt       <= '0;
                        fir_ready <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (cnt == CNT_LAST) begin
                        fir_ready <= 1'b0;
                        primed    <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A burst only starts with m_valid low, so the capture never
            // overwrites an output that has not been accepted yet.
            if (state == BURST && cnt == CNT_CAPT && primed) begin
                m_data  <= fir_out;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder with default parameters (18/64/4).
module tb_fir_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_data;
    logic [17:0] fir_sig;
    logic        fir_ready;
    logic [17:0] fir_out;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_data;
    logic        busy;

    logic [17:0] fir_const;
    logic        use_model;

    int vectors = 0;
    int miscompares = 0;

    // Filter stand-in: either a fixed value or the current sample plus 1000.
    assign fir_out = use_model ? (fir_sig + 18'd1000) : fir_const;

    fir_sample_feeder #(.WIDTH(18), .TAPS(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_sig(fir_sig), .fir_ready(fir_ready), .fir_out(fir_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until fir_ready reaches lvl; n = ticks taken, or -1 on timeout.
    task automatic wait_fr(input logic lvl, input int lim, output int n);
        n = 0;
        while (fir_ready !== lvl && n < lim) begin
            tick();
            n++;
        end
        if (fir_ready !== lvl) n = -1;
    endtask

    task automatic do_reset;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        use_model = 1'b0; fir_const = '0;
        #3;
        vectors++;
        if (s_ready !== 1'b1 || fir_ready !== 1'b0 || busy !== 1'b0 ||
            m_valid !== 1'b0 || m_data !== 18'h0 || fir_sig !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_state: got s_ready=%b fir_ready=%b busy=%b m_valid=%b m_data=%h fir_sig=%h expected 1 0 0 0 0 0",
                     s_ready, fir_ready, busy, m_valid, m_data, fir_sig);
        end
        do_reset();
    endtask

    task automatic test_single;
        int n;
        int bad;
        do_reset();
        s_valid = 1'b1; s_data = 18'sd100;
        tick();
        s_valid = 1'b0;
        vectors++;
        if (fir_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_push_edge: got fir_ready=%b expected 0", fir_ready);
        end
        tick();
        vectors++;
        if (fir_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pop_edge: got fir_ready=%b busy=%b expected 1 1", fir_ready, busy);
        end
        n = 0; bad = 0;
        while (fir_ready === 1'b1 && n < 200) begin
            if (fir_sig !== 18'd100 || m_valid !== 1'b0 || busy !== 1'b1) bad++;
            n++;
            tick();
        end
        vectors++;
        if (n != 64) begin
            miscompares++;
            $display("FAIL single_burst_len: got %0d expected 64", n);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL single_burst_hold: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_burst;
        int n;
        s_valid = 1'b1; s_data = 18'sd55;
        tick();
        s_valid = 1'b0;
        wait_fr(1'b1, 10, n);
        repeat (20) tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (fir_ready !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got fir_ready=%b busy=%b m_valid=%b s_ready=%b expected 0 0 0 1",
                     fir_ready, busy, m_valid, s_ready);
        end
        tick();
        rst = 1'b0;
        wait_fr(1'b1, 10, n);
        vectors++;
        if (n != -1) begin
            miscompares++;
            $display("FAIL reset_no_resume: got burst after %0d cycles expected none", n);
        end
    endtask

    task automatic test_prime;
        int n;
        int bad;
        do_reset();
        fir_const = 18'sd7;
        s_valid = 1'b1; s_data = 18'sd100;
        tick();
        s_data = 18'sd200;
        tick();
        s_valid = 1'b0;
        bad = 0; n = 0;
        while (fir_ready === 1'b1 && n < 200) begin
            if (m_valid !== 1'b0) bad++;
            n++;
            tick();
        end
        vectors++;
        if (bad != 0 || n != 64) begin
            miscompares++;
            $display("FAIL prime_first_burst: got len=%0d m_valid_cycles=%0d expected 64 0", n, bad);
        end
        wait_fr(1'b1, 10, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL prime_gap: got %0d expected 1", n);
        end
        vectors++;
        if (m_valid !== 1'b0 || fir_sig !== 18'd200) begin
            miscompares++;
            $display("FAIL prime_cnt0: got m_valid=%b fir_sig=%h expected 0 %h", m_valid, fir_sig, 18'd200);
        end
        tick();
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL prime_cnt1: got m_valid=%b expected 0", m_valid);
        end
        tick();
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 18'd7) begin
            miscompares++;
            $display("FAIL prime_capture: got m_valid=%b m_data=%h expected 1 %h", m_valid, m_data, 18'd7);
        end
    endtask

    // Continues from test_prime: output pending, second burst in progress.
    task automatic test_backpressure;
        int n;
        int bad;
        fir_const = 18'sd9;
        for (int k = 1; k <= 6; k++) begin
            s_valid = 1'b1; s_data = 18'(k);
            tick();
        end
        s_valid = 1'b0;
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got s_ready=%b expected 0", s_ready);
        end
        wait_fr(1'b0, 100, n);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (busy !== 1'b0 || m_valid !== 1'b1 || m_data !== 18'd7) bad++;
            tick();
        end
        vectors++;
        if (n < 0 || bad != 0) begin
            miscompares++;
            $display("FAIL bp_stall: got wait=%0d bad=%0d expected >=0 0", n, bad);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: got m_valid=%b expected 0", m_valid);
        end
        wait_fr(1'b1, 10, n);
        vectors++;
        if (n < 1 || n > 2) begin
            miscompares++;
            $display("FAIL bp_restart: got %0d cycles expected 1..2", n);
        end
        vectors++;
        if (fir_sig !== 18'd1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_head: got fir_sig=%h s_ready=%b expected 1 1", fir_sig, s_ready);
        end
    endtask

    task automatic test_negative;
        int n;
        int bad;
        do_reset();
        fir_const = 18'h20000;
        s_valid = 1'b1; s_data = 18'sd0;
        tick();
        s_data = -18'sd5;
        tick();
        s_valid = 1'b0;
        wait_fr(1'b0, 100, n);
        wait_fr(1'b1, 10, n);
        bad = 0; n = 0;
        while (fir_ready === 1'b1 && n < 200) begin
            if (fir_sig !== 18'h3FFFB) bad++;
            n++;
            tick();
        end
        vectors++;
        if (bad != 0 || n != 64) begin
            miscompares++;
            $display("FAIL neg_fir_sig: got len=%0d bad=%0d expected 64 0", n, bad);
        end
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 18'h20000) begin
            miscompares++;
            $display("FAIL neg_capture: got m_valid=%b m_data=%h expected 1 20000", m_valid, m_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] samp [10];
        logic [17:0] got  [10];
        int ngot;
        int bursts;
        int idle;
        int min_gap;
        logic prev_fr;
        do_reset();
        for (int k = 0; k < 10; k++) samp[k] = 18'(50 * k + 3);
        use_model = 1'b1;
        m_ready = 1'b1;
        ngot = 0; bursts = 0; idle = 0; min_gap = 999; prev_fr = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    logic ok;
                    int g;
                    s_valid = 1'b1; s_data = samp[k];
                    g = 0;
                    do begin
                        ok = s_ready;
                        tick();
                        g++;
                    end while (!ok && g < 300);
                end
                s_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 900; c++) begin
                    tick();
                    if (m_valid === 1'b1 && ngot < 10) begin
                        got[ngot] = m_data;
                        ngot++;
                    end
                    if (fir_ready === 1'b1 && prev_fr == 1'b0) begin
                        if (bursts > 0 && idle < min_gap) min_gap = idle;
                        bursts++;
                    end
                    idle = (fir_ready === 1'b1) ? 0 : idle + 1;
                    prev_fr = fir_ready;
                end
            end
        join
        vectors++;
        if (ngot != 9 || bursts != 10) begin
            miscompares++;
            $display("FAIL b2b_count: got outputs=%0d bursts=%0d expected 9 10", ngot, bursts);
        end
        for (int j = 0; j < 9 && j < ngot; j++) begin
            vectors++;
            if (got[j] !== samp[j+1] + 18'd1000) begin
                miscompares++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", j, got[j], samp[j+1] + 18'd1000);
            end
        end
        vectors++;
        if (min_gap < 1) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d expected >=1", min_gap);
        end
        use_model = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_burst();
        test_prime();
        test_backpressure();
        test_negative();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
